// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC generator upstream of the instruction-memory fetch stage.
//   Owns the word-addressed fetch PC. It takes redirects from execute and holds
//   any redirect that arrives during a stall. It raises the one-cycle flush that
//   kills wrong-path instructions.
// Optional feature macro: FETCH_BTB_EN adds a direct-mapped BTB that steers
//   sequential fetch.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   n_stall           1 = pipeline advances this cycle
//   ex_redirect       redirect request from execute, target ex_target
//   ex_br_valid/pc/taken  resolved control transfer (BTB update only)
//   pc                registered fetch PC
//   npc, npc_enn      combinational redirect address / select (1 = fetch npc)
//   flush             combinational kill of younger instructions (== npc_enn)
//   if_pred_taken     registered: current fetch was steered by the BTB
module fetch_pc_gen #(
    parameter logic [24:0] RESET_PC    = 25'd16346,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        n_stall,
    input  logic        ex_redirect,
    input  logic [24:0] ex_target,
    input  logic        ex_br_valid,
    input  logic [24:0] ex_br_pc,
    input  logic        ex_br_taken,
    output logic [24:0] pc,
    output logic [24:0] npc,
    output logic        npc_enn,
    output logic        flush,
    output logic        if_pred_taken
);

    localparam int unsigned PC_W = 25;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    logic [0:0]      pend_q, pend_d;
    logic            pred_q, pred_d;

    logic            hit;
    logic [PC_W-1:0] next_seq;

`ifdef FETCH_BTB_EN
    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W;

    logic [BTB_ENTRIES-1:0] btb_vld_q, btb_vld_d;
    logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
    logic [TAG_W-1:0]       btb_tag_d [BTB_ENTRIES];
    logic [PC_W-1:0]        btb_tgt_q [BTB_ENTRIES];
    logic [PC_W-1:0]        btb_tgt_d [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;

    // Lookup reads the registered contents, so a same-cycle update is not visible.
    assign lk_idx   = pc_q[IDX_W-1:0];
    assign hit      = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == pc_q[PC_W-1:IDX_W]);
    assign next_seq = hit ? btb_tgt_q[lk_idx] : PC_W'(pc_q + PC_W'(1));

    assign up_idx = ex_br_pc[IDX_W-1:0];
    assign up_tag = ex_br_pc[PC_W-1:IDX_W];

    // BTB update: allocate on taken, invalidate on not-taken only if the tag matches.
    always_comb begin
        btb_vld_d = btb_vld_q;
        btb_tag_d = btb_tag_q;
        btb_tgt_d = btb_tgt_q;
        if (ex_br_valid) begin
            if (ex_br_taken) begin
                btb_vld_d[up_idx] = 1'b1;
                btb_tag_d[up_idx] = up_tag;
                btb_tgt_d[up_idx] = ex_target;
            end else if (btb_tag_q[up_idx] == up_tag) begin
                btb_vld_d[up_idx] = 1'b0;
            end
        end
    end

    // Only the valid bits need a reset; tag/target are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_vld_q <= '0;
        end else begin
            btb_vld_q <= btb_vld_d;
        end
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
    end
`else
    logic unused_br;

    assign hit       = 1'b0;
    assign next_seq  = PC_W'(pc_q + PC_W'(1));
    assign unused_br = ^{ex_br_valid, ex_br_pc, ex_br_taken};
`endif

    // Redirect select: a fresh redirect wins over a held one.
    always_comb begin
        npc     = '0;
        npc_enn = 1'b0;
        if (!rst) begin
            if (ex_redirect) begin
                npc     = ex_target;
                npc_enn = 1'b1;
            end else if (pend_q == ST_HOLD) begin
                npc     = tgt_q;
                npc_enn = 1'b1;
            end
        end
    end

    assign flush = npc_enn;

    // Next-state: consume the redirect on an advancing cycle, otherwise hold it.
    always_comb begin
        pc_d   = pc_q;
        tgt_d  = tgt_q;
        pend_d = pend_q;
        pred_d = pred_q;
        if (npc_enn) begin
            pred_d = 1'b0;
            if (n_stall) begin
                pc_d   = PC_W'(npc + PC_W'(1));
                pend_d = ST_RUN;
            end else begin
                tgt_d  = npc;
                pend_d = ST_HOLD;
            end
        end else if (n_stall) begin
            pc_d   = next_seq;
            pred_d = hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            tgt_q  <= '0;
            pend_q <= ST_RUN;
            pred_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            tgt_q  <= tgt_d;
            pend_q <= pend_d;
            pred_q <= pred_d;
        end
    end

    assign pc            = pc_q;
    assign if_pred_taken = pred_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: vector table plus a BTB/branch-update sequence.
module tb_fetch_pc_gen;

    logic        clk;
    logic        rst;
    logic        n_stall;
    logic        ex_redirect;
    logic [24:0] ex_target;
    logic        ex_br_valid;
    logic [24:0] ex_br_pc;
    logic        ex_br_taken;
    logic [24:0] pc;
    logic [24:0] npc;
    logic        npc_enn;
    logic        flush;
    logic        if_pred_taken;

    int n_checks;
    int n_fail;

    fetch_pc_gen dut (
        .clk          (clk),
        .rst          (rst),
        .n_stall      (n_stall),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .ex_br_valid  (ex_br_valid),
        .ex_br_pc     (ex_br_pc),
        .ex_br_taken  (ex_br_taken),
        .pc           (pc),
        .npc          (npc),
        .npc_enn      (npc_enn),
        .flush        (flush),
        .if_pred_taken(if_pred_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ns;
        logic        red;
        logic [24:0] tgt;
        logic        chk;
        logic [24:0] epc;
        logic [24:0] enpc;
        logic        eenn;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ns, input logic red, input logic [24:0] tgt,
                       input logic chk, input logic [24:0] epc, input logic [24:0] enpc,
                       input logic eenn);
        vec_t v;
        v.rst = r; v.ns = ns; v.red = red; v.tgt = tgt;
        v.chk = chk; v.epc = epc; v.enpc = enpc; v.eenn = eenn;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ns, input logic red, input logic [24:0] tgt,
                         input logic bv, input logic [24:0] bpc, input logic bt);
        rst = r; n_stall = ns; ex_redirect = red; ex_target = tgt;
        ex_br_valid = bv; ex_br_pc = bpc; ex_br_taken = bt;
    endtask

    logic [24:0] exp_d_pc;
    logic        exp_d_pred;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(1'b1, 1'b1, 1'b0, 25'd0, 1'b0, 25'd0, 1'b0);

        //  rst  ns  red  tgt             chk  pc              npc             enn
        add(1, 1, 0, 25'd0,         0, 25'd0,        25'd0,         0);
        add(1, 1, 0, 25'd0,         1, 25'd16346,    25'd0,         0);
        add(0, 1, 0, 25'd0,         1, 25'd16346,    25'd0,         0);
        add(0, 1, 0, 25'd0,         1, 25'd16347,    25'd0,         0);
        add(0, 1, 0, 25'd0,         1, 25'd16348,    25'd0,         0);
        add(0, 1, 1, 25'd99,        1, 25'd16349,    25'd99,        1);
        add(0, 1, 1, 25'd40,        1, 25'd100,      25'd40,        1);
        add(0, 1, 0, 25'd0,         1, 25'd41,       25'd0,         0);
        // redirect during a stall, held three more cycles
        add(0, 0, 1, 25'd7,         1, 25'd42,       25'd7,         1);
        add(0, 0, 0, 25'd0,         1, 25'd42,       25'd7,         1);
        add(0, 0, 0, 25'd0,         1, 25'd42,       25'd7,         1);
        add(0, 0, 0, 25'd0,         1, 25'd42,       25'd7,         1);
        add(0, 1, 0, 25'd0,         1, 25'd42,       25'd7,         1);
        add(0, 1, 0, 25'd0,         1, 25'd8,        25'd0,         0);
        // back-to-back redirects while held: newest wins
        add(0, 0, 1, 25'd7,         1, 25'd9,        25'd7,         1);
        add(0, 0, 1, 25'd9,         1, 25'd9,        25'd9,         1);
        add(0, 0, 0, 25'd0,         1, 25'd9,        25'd9,         1);
        add(0, 1, 0, 25'd0,         1, 25'd9,        25'd9,         1);
        add(0, 1, 0, 25'd0,         1, 25'd10,       25'd0,         0);
        // plain stall
        add(0, 0, 0, 25'd0,         1, 25'd11,       25'd0,         0);
        add(0, 1, 0, 25'd0,         1, 25'd11,       25'd0,         0);
        // wrap-around
        add(0, 1, 1, 25'h1FFFFFE,   1, 25'd12,       25'h1FFFFFE,   1);
        add(0, 1, 0, 25'd0,         1, 25'h1FFFFFF,  25'd0,         0);
        add(0, 1, 1, 25'h1FFFFFF,   1, 25'd0,        25'h1FFFFFF,   1);
        add(0, 1, 0, 25'd0,         1, 25'd0,        25'd0,         0);
        add(0, 1, 0, 25'd0,         1, 25'd1,        25'd0,         0);
        // reset overrides redirect and clears a pending hold
        add(1, 1, 1, 25'd5,         1, 25'd2,        25'd0,         0);
        add(1, 0, 1, 25'd5,         1, 25'd16346,    25'd0,         0);
        add(0, 0, 0, 25'd0,         1, 25'd16346,    25'd0,         0);
        add(0, 1, 0, 25'd0,         1, 25'd16346,    25'd0,         0);
        add(0, 1, 0, 25'd0,         1, 25'd16347,    25'd0,         0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].ns, vecs[i].red, vecs[i].tgt, 1'b0, 25'd0, 1'b0);
            #1;
            if (vecs[i].chk) begin
                check("pc", i, 32'(pc), 32'(vecs[i].epc));
                check("npc_enn", i, 32'(npc_enn), 32'(vecs[i].eenn));
                check("flush", i, 32'(flush), 32'(vecs[i].eenn));
                if (vecs[i].eenn) check("npc", i, 32'(npc), 32'(vecs[i].enpc));
            end
        end

        // Branch-update sequence; pc is 16348 here.
`ifdef FETCH_BTB_EN
        exp_d_pc   = 25'd5;
        exp_d_pred = 1'b1;
`else
        exp_d_pc   = 25'd21;
        exp_d_pred = 1'b0;
`endif
        @(negedge clk);  // taken branch at pc 20 -> target 5, no redirect
        drive(1'b0, 1'b1, 1'b0, 25'd5, 1'b1, 25'd20, 1'b1);
        #1;
        check("seq_a_pc", 100, 32'(pc), 32'd16348);
        @(negedge clk);  // redirect to 19 so that pc 20 is fetched next
        drive(1'b0, 1'b1, 1'b1, 25'd19, 1'b0, 25'd0, 1'b0);
        #1;
        check("seq_b_npc", 101, 32'(npc), 32'd19);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 25'd0, 1'b0, 25'd0, 1'b0);
        #1;
        check("seq_c_pc", 102, 32'(pc), 32'd20);
        check("seq_c_pred", 102, 32'(if_pred_taken), 32'd0);
        @(negedge clk);  // not-taken resolution for pc 20 clears the entry
        drive(1'b0, 1'b1, 1'b0, 25'd0, 1'b1, 25'd20, 1'b0);
        #1;
        check("seq_d_pc", 103, 32'(pc), 32'(exp_d_pc));
        check("seq_d_pred", 103, 32'(if_pred_taken), 32'(exp_d_pred));
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 25'd19, 1'b0, 25'd0, 1'b0);
        #1;
        check("seq_e_enn", 104, 32'(npc_enn), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 25'd0, 1'b0, 25'd0, 1'b0);
        #1;
        check("seq_f_pc", 105, 32'(pc), 32'd20);
        @(negedge clk);
        #1;
        check("seq_g_pc", 106, 32'(pc), 32'd21);
        check("seq_g_pred", 106, 32'(if_pred_taken), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
